serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle parametrised subtractor that computes A − B − borrow_in over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, least-significant digit first. It produces the difference, the unsigned borrow-out and the signed overflow flag. It is the sequential successor to the single-bit half subtractor. It sits behind a start/busy/done handshake so an area-lean datapath can share one narrow borrow stage across a wide operand.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising clk edge while state is IDLE or DONE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; the results are final while it is high.
- difference  output  WIDTH  (A − B − borrow_in) mod 2^WIDTH.
- borrow  output  1  unsigned borrow-out; 1 iff A < B + borrow_in.
- overflow  output  1  two's-complement overflow of the subtraction.

## Operation
- States:
  - IDLE: reset state.
  - RUN: stepping through digits.
  - DONE: one cycle with results final.
- Transitions:
  - IDLE → RUN on start=1.
  - RUN → DONE after the STEPS-th step.
  - DONE → RUN on start=1.
  - DONE → IDLE on start=0.
- start is ignored while in RUN. Inputs A, B and borrow_in are don't-care outside accepting edges.
- On accept, load the internal registers:
  - opA ← A, opB ← B
  - brw ← borrow_in
  - work ← 0
  - cnt ← 0
  - signA ← A[WIDTH-1], signB ← B[WIDTH-1]
- Each RUN step:
  - Form the DIGIT+1-bit value t = {1'b0, opA[DIGIT-1:0]} − {1'b0, opB[DIGIT-1:0]} − brw.
  - Shift t[DIGIT-1:0] into work from the MSB side.
  - brw ← t[DIGIT].
  - Shift opA and opB right by DIGIT.
  - cnt ← cnt + 1.
- On the last step (cnt = STEPS−1), commit the output registers:
  - difference ← final work.
  - borrow ← final brw.
  - overflow ← (signA ^ signB) & (signA ^ final work[WIDTH-1]).
- Outputs difference, borrow and overflow are registers. They change only at a commit edge or at reset, and they hold their last value indefinitely, including through RUN of a later operation.
- The cnt width is clog2(STEPS) with a minimum of 1 bit. No wrap-around is visible externally.
- Reset at any time, including mid-RUN, immediately forces:
  - state = IDLE
  - busy = 0, done = 0
  - difference = 0, borrow = 0, overflow = 0
  - all internal registers cleared
- An operation in flight when reset asserts is discarded; nothing is committed.
- start asserted during rst is ignored. The first accept can occur on the first rising edge after rst deasserts.

## Timing
- Let E0 be the accepting edge. Steps occur on edges E1..E_STEPS.
- The commit happens at E_STEPS. done = 1 for the cycle following E_STEPS.
- Latency from the accepting edge to done is STEPS edges. Examples: WIDTH=8, DIGIT=1 → 8; WIDTH=8, DIGIT=4 → 2.
- busy rises at E0 and falls at E_STEPS.
- done falls at E_STEPS+1, unless a new operation starts there. In that case done still falls and busy rises in the same cycle.
- Back-to-back issue (start held high) gives a throughput of one result per STEPS+1 cycles.
- busy and done are never high together.

## Test plan
- Basic subtraction: WIDTH=8, DIGIT=1; A=0x05, B=0x03, borrow_in=0, one start pulse.
  - Required: difference=0x02, borrow=0, overflow=0, done high exactly 8 edges after the accept.
  - busy is high for 8 cycles, and difference holds its old value until commit.
- Borrow-out and borrow-in:
  - A=0x03, B=0x05 → difference=0xFE, borrow=1, overflow=0.
  - A=0x00, B=0x00, borrow_in=1 → difference=0xFF, borrow=1, overflow=0.
- Signed overflow:
  - A=0x80, B=0x01 → difference=0x7F, borrow=0, overflow=1.
  - A=0x7F, B=0xFF → difference=0x80, borrow=1, overflow=1.
- Handshake: pulse start again at E3 with A=0xFF, B=0x00.
  - Required: the pulse is ignored and the first result is unchanged.
  - Holding start high through DONE launches the next operation with busy high in the cycle after done.
- Reset mid-operation: assert rst between E4 and E5.
  - Required: busy, done, difference, borrow and overflow drop to 0 asynchronously (without waiting for a clock edge), and no done pulse ever appears.
  - A new start after release yields correct results.
- Digit mode, WIDTH=8, DIGIT=4: A=0x3C, B=0x4D.
  - Required: done 2 edges after the accept, difference=0xEF, borrow=1, overflow=0.
  - Finish with 1000 random operand pairs checked against a behavioural A − B − borrow_in model for both DIGIT=1 and DIGIT=4.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial two's-complement subtractor.
// Computes A - B - borrow_in over WIDTH/DIGIT cycles, DIGIT bits per cycle,
// least-significant digit first, behind a start/busy/done handshake.
// One narrow borrow stage is shared across the whole operand width.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    logic [1:0]         state_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic               brw_r;
    logic [WIDTH-1:0]   work_r;
    logic [CW-1:0]      cnt_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   diff_r;
    logic               borrow_r;
    logic               ovf_r;

    logic [DIGIT:0]       t_s;
    logic [WIDTH+DIGIT-1:0] shift_s;
    logic [WIDTH-1:0]     work_next_s;
    logic                 ovf_next_s;
    logic                 accept_s;
    logic                 last_s;

    // Digit borrow stage, work shift-in and overflow of the value being committed.
    always_comb begin
        t_s         = {1'b0, opa_r[DIGIT-1:0]} - {1'b0, opb_r[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, brw_r};
        shift_s     = {t_s[DIGIT-1:0], work_r};
        work_next_s = shift_s[WIDTH+DIGIT-1:DIGIT];
        ovf_next_s  = (sign_a_r ^ sign_b_r) & (sign_a_r ^ work_next_s[WIDTH-1]);
        last_s      = (cnt_r == LAST_CNT);
    end

    // A request is only honoured from IDLE or DONE; start is ignored during RUN.
    always_comb begin
        if ((state_r == IDLE) || (state_r == DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM, operand/work registers and committed result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            opa_r    <= '0;
            opb_r    <= '0;
            brw_r    <= 1'b0;
            work_r   <= '0;
            cnt_r    <= '0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        opa_r    <= A;
                        opb_r    <= B;
                        brw_r    <= borrow_in;
                        work_r   <= '0;
                        cnt_r    <= '0;
                        sign_a_r <= A[WIDTH-1];
                        sign_b_r <= B[WIDTH-1];
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    work_r <= work_next_s;
                    brw_r  <= t_s[DIGIT];
                    opa_r  <= opa_r >> DIGIT;
                    opb_r  <= opb_r >> DIGIT;
                    if (last_s) begin
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        cnt_r    <= '0;
                        diff_r   <= work_next_s;
                        borrow_r <= t_s[DIGIT];
                        ovf_r    <= ovf_next_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign difference = diff_r;
    assign borrow     = borrow_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor
// in bit-serial (DIGIT=1) and nibble (DIGIT=4) configurations.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start1;
    logic       start4;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       bi_in;

    logic       busy1, done1, borrow1, ovf1;
    logic [7:0] diff1;
    logic       busy4, done4, borrow4, ovf4;
    logic [7:0] diff4;

    logic       sel;
    logic       c_busy, c_done, c_borrow, c_ovf;
    logic [7:0] c_diff;

    logic [7:0] last_diff [2];

    int unsigned n_cmp;
    int unsigned n_bad;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a_in), .B(b_in),
        .borrow_in(bi_in), .busy(busy1), .done(done1), .difference(diff1),
        .borrow(borrow1), .overflow(ovf1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a_in), .B(b_in),
        .borrow_in(bi_in), .busy(busy4), .done(done4), .difference(diff4),
        .borrow(borrow4), .overflow(ovf4)
    );

    assign c_busy   = sel ? busy4   : busy1;
    assign c_done   = sel ? done4   : done1;
    assign c_diff   = sel ? diff4   : diff1;
    assign c_borrow = sel ? borrow4 : borrow1;
    assign c_ovf    = sel ? ovf4    : ovf1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, required completion", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) start4 = v;
        else   start1 = v;
    endtask

    // Behavioural reference: {overflow, borrow, difference}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] full;
        logic       ov;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        ov   = (a[7] != b[7]) && (full[7] != a[7]);
        return {ov, full[8], full[7:0]};
    endfunction

    // One operation with optional ignored start pulse at E3.
    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input bit mid, input string tag);
        int n;
        int steps;
        steps = s ? 2 : 8;
        sel   = s;
        @(negedge clk);
        set_start(s, 1'b1);
        a_in = a; b_in = b; bi_in = bi;
        @(negedge clk);
        set_start(s, 1'b0);
        n = 0;
        while (c_done !== 1'b1 && n < 20) begin
            check_val({tag, " busy"}, 32'(c_busy), 32'd1);
            check_val({tag, " hold"}, 32'(c_diff), 32'(last_diff[s]));
            if (mid && n == 2) begin
                set_start(s, 1'b1);
                a_in = 8'hFF; b_in = 8'h00;
            end else begin
                set_start(s, 1'b0);
            end
            @(negedge clk);
            n++;
        end
        check_val({tag, " latency"}, 32'(n), 32'(steps));
        check_val({tag, " done"}, 32'(c_done), 32'd1);
        check_val({tag, " busy@done"}, 32'(c_busy), 32'd0);
        check_val({tag, " diff"}, 32'(c_diff), 32'(ed));
        check_val({tag, " borrow"}, 32'(c_borrow), 32'(eb));
        check_val({tag, " ovf"}, 32'(c_ovf), 32'(eo));
        last_diff[s] = ed;
        @(negedge clk);
        check_val({tag, " done fall"}, 32'(c_done), 32'd0);
        check_val({tag, " idle busy"}, 32'(c_busy), 32'd0);
        check_val({tag, " held"}, 32'(c_diff), 32'(ed));
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb;
        logic       rbi;
        logic [9:0] m;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
        a_in = 8'h00; b_in = 8'h00; bi_in = 1'b0; sel = 1'b0;
        last_diff[0] = 8'h00; last_diff[1] = 8'h00;

        // Reset state, with start asserted during reset
        repeat (2) @(negedge clk);
        check_val("rst busy1", 32'(busy1), 32'd0);
        check_val("rst done1", 32'(done1), 32'd0);
        check_val("rst diff1", 32'(diff1), 32'd0);
        check_val("rst borrow1", 32'(borrow1), 32'd0);
        check_val("rst ovf1", 32'(ovf1), 32'd0);
        check_val("rst busy4", 32'(busy4), 32'd0);
        check_val("rst diff4", 32'(diff4), 32'd0);
        start1 = 1'b0; start4 = 1'b0;
        rst = 1'b0;

        // Basic subtraction with an ignored start pulse at E3
        do_op(1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, "basic");

        // Back-to-back: start held through DONE
        sel = 1'b0;
        @(negedge clk);
        start1 = 1'b1; a_in = 8'h05; b_in = 8'h03; bi_in = 1'b0;
        @(negedge clk);
        n = 0;
        while (done1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b lat1", 32'(n), 32'd8);
        check_val("b2b diff1", 32'(diff1), 32'h02);
        a_in = 8'h10; b_in = 8'h01;
        @(negedge clk);
        check_val("b2b busy", 32'(busy1), 32'd1);
        check_val("b2b done", 32'(done1), 32'd0);
        check_val("b2b hold", 32'(diff1), 32'h02);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b lat2", 32'(n), 32'd8);
        check_val("b2b diff2", 32'(diff1), 32'h0F);
        check_val("b2b borrow2", 32'(borrow1), 32'd0);
        last_diff[0] = 8'h0F;
        @(negedge clk);
        check_val("b2b idle", 32'(done1), 32'd0);

        // Borrow and overflow vectors
        do_op(1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "brwout");
        do_op(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "brwin");
        do_op(1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "ovfneg");
        do_op(1'b0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, "ovfpos");

        // Reset between E4 and E5
        sel = 1'b0;
        @(negedge clk);
        start1 = 1'b1; a_in = 8'h44; b_in = 8'h11; bi_in = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("mrst busy", 32'(busy1), 32'd0);
        check_val("mrst done", 32'(done1), 32'd0);
        check_val("mrst diff", 32'(diff1), 32'd0);
        check_val("mrst borrow", 32'(borrow1), 32'd0);
        check_val("mrst ovf", 32'(ovf1), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_diff[0] = 8'h00; last_diff[1] = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_val("mrst nodone", 32'(done1), 32'd0);
        end
        do_op(1'b0, 8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, "postrst");

        // Nibble mode
        do_op(1'b1, 8'h3C, 8'h4D, 1'b0, 8'hEF, 1'b1, 1'b0, 1'b0, "digit4");

        // Random operands against the behavioural model, both configurations
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1000; i++) begin
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rbi = 1'($urandom);
                m   = model(ra, rb, rbi);
                do_op(1'(s), ra, rb, rbi, m[7:0], m[8], m[9], 1'b0, s == 0 ? "rnd1" : "rnd4");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
